raw_capture_writer: RTL and testbench
=====================================

// Module: raw_capture_writer
// PURPOSE
//  Write side of the raw-sample BRAM (16384 x 16) that the beamforming controller reads.
//  Takes an interleaved multichannel ADC stream (ch0..ch7 per time step, with no backpressure).
//  Transposes the stream into channel-major layout: addr = ch*SAMPLES + idx.
//  Flags a completed block so the controller can start filtering.
// PARAMETERS
//  NUM_CH   8     channels per frame; power of 2
//  SAMPLES  2048  time samples per channel per block; power of 2
//  DATA_W   16    sample width
//  ADDR_W   14    RAM address width = log2(NUM_CH*SAMPLES)
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       asynchronous, active-low
//  arm           in   1       one-cycle pulse; starts a capture (accepted only in IDLE)
//  s_valid       in   1       sample strobe from ADC front end
//  s_sof         in   1       qualifies the s_valid sample as ch0 of a frame
//  s_data        in   DATA_W  sample
//  ram_wr_en     out  1       RAM write strobe
//  ram_wr_addr   out  ADDR_W  RAM write address
//  ram_wr_data   out  DATA_W  RAM write data
//  busy          out  1       high in WAIT_SOF and CAPTURE
//  capture_done  out  1       high in DONE until done_ack
//  sync_err      out  1       sticky framing error; cleared by an accepted arm
//  done_ack      in   1       consumer releases the buffer
// BEHAVIOUR
//  Reset: state=IDLE; ch=0; idx=0; all outputs 0. Mid-capture reset aborts; RAM contents are undefined.
//  FSM: IDLE -arm-> WAIT_SOF -(s_valid&s_sof)-> CAPTURE -(last write)-> DONE -done_ack-> IDLE.
//  arm outside IDLE: ignored. done_ack outside DONE: ignored.
//  WAIT_SOF: samples without s_sof are dropped. The s_sof sample is written as ch0, idx0; next ch=1.
//  CAPTURE: each s_valid writes {ch,idx}. ch increments and wraps at NUM_CH-1; idx increments on each ch wrap.
//  Write timing: registered. ram_wr_* are valid the cycle after the accepted sample. No stalls.
//  Framing check in CAPTURE:
//   - s_sof with ch!=0 -> set sync_err. That sample restarts the block as ch0/idx0; stay in CAPTURE.
//   - ch==0 without s_sof -> set sync_err. Drop the sample; go to WAIT_SOF; idx=0.
//  Last write: ch=NUM_CH-1, idx=SAMPLES-1 (addr 16383) -> DONE.
//   capture_done rises on the same edge as that ram_wr_en.
//  DONE: all input samples are dropped. No RAM writes.
//  done_ack and arm in the same cycle in DONE: go to IDLE; arm is ignored.
//  Address arithmetic is pure concatenation; no overflow is possible.
// CONFIGURATION
//  RAW_CAPTURE_DROP_CNT_EN defined:
//   - adds output drop_cnt[15:0]; reset 0; cleared on an accepted arm.
//   - increments on every s_valid dropped in WAIT_SOF, DONE or IDLE; saturates at 16'hFFFF.
//  Not defined: no drop_cnt port or logic.
// STRUCTURE
//  Shared package raw_cap_pkg:
//   - FSM state localparams (IDLE=0, WAIT_SOF=1, CAPTURE=2, DONE=3)
//   - NUM_CH/SAMPLES/ADDR_W defaults, shared with the controller's RAM geometry
//  One sub-module: raw_cap_addr_gen (ch/idx counters, wrap, last flag).
//  FSM, framing check and write registers stay in the top module.
// TESTING
//  1. arm; 2048 frames, each ch0..7 with s_sof on ch0, data={ch,idx[11:0]}
//     -> 16384 writes; addr 2048*ch+idx holds {ch,idx}; capture_done after write 16383.
//  2. arm; 5 non-sof samples, then a frame
//     -> no writes for the 5; first write addr 0; with drop counter, drop_cnt=5.
//  3. In CAPTURE at ch=3, assert s_sof
//     -> sync_err=1; write lands at addr 0; the next sample goes to addr 2048.
//  4. arm pulse during CAPTURE and during DONE -> no state change; ch/idx unchanged.
//  5. reset low at idx=100 -> outputs 0 asynchronously; IDLE; a new arm restarts at addr 0.
//  6. In DONE, hold done_ack=0 for 50 cycles with s_valid=1
//     -> capture_done stays 1, no writes; done_ack -> IDLE next cycle.

Source files
------------

// File: rtl/raw_cap_pkg.sv
// Shared geometry and FSM encoding for the raw-sample capture buffer.
// The controller reading the RAM uses the same NUM_CH/SAMPLES/ADDR_W values.
package raw_cap_pkg;

    localparam int NUM_CH  = 8;
    localparam int SAMPLES = 2048;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 14;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int IDX_W   = $clog2(SAMPLES);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_SOF = ST_WAIT_SOF,
        CAPTURE  = ST_CAPTURE,
        DONE     = ST_DONE
    } state_t;

endpackage

// File: rtl/raw_cap_addr_gen.sv
// Channel/index counters for channel-major transposition.
// addr = {ch, idx} == ch*SAMPLES + idx; last flags the final slot of the block.
module raw_cap_addr_gen
    import raw_cap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              restart,
    input  logic              advance,
    output logic [CH_W-1:0]   ch,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

    logic [CH_W-1:0]  ch_reg;
    logic [IDX_W-1:0] idx_reg;

    // clear -> slot 0; restart -> slot after a ch0/idx0 write; advance -> next slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_reg  <= '0;
            idx_reg <= '0;
        end else if (clear) begin
            ch_reg  <= '0;
            idx_reg <= '0;
        end else if (restart) begin
            ch_reg  <= CH_W'(1);
            idx_reg <= '0;
        end else if (advance) begin
            if (ch_reg == CH_LAST) begin
                ch_reg  <= '0;
                idx_reg <= idx_reg + IDX_W'(1);
            end else begin
                ch_reg  <= ch_reg + CH_W'(1);
            end
        end
    end

    assign ch   = ch_reg;
    assign idx  = idx_reg;
    assign addr = {ch_reg, idx_reg};
    assign last = (ch_reg == CH_LAST) && (idx_reg == IDX_LAST);

endmodule

// File: rtl/raw_capture_writer.sv
// Write side of the raw-sample RAM: transposes an interleaved ch0..ch7 ADC
// stream into channel-major layout and flags a completed block.
// Optional feature: RAW_CAPTURE_DROP_CNT_EN adds a saturating drop counter.
module raw_capture_writer
    import raw_cap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              s_valid,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              busy,
    output logic              capture_done,
    output logic              sync_err,
    input  logic              done_ack
`ifdef RAW_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    state_t state_reg, state_next;

    logic              cnt_clear, cnt_restart, cnt_advance;
    logic [CH_W-1:0]   ch;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] slot_addr;
    logic              slot_last;

    logic              wr_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic              err_set, err_clear;

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              sync_err_reg;

    raw_cap_addr_gen u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .restart (cnt_restart),
        .advance (cnt_advance),
        .ch      (ch),
        .idx     (idx),
        .addr    (slot_addr),
        .last    (slot_last)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // next state, framing check and write decision
    always_comb begin
        state_next   = state_reg;
        cnt_clear    = 1'b0;
        cnt_restart  = 1'b0;
        cnt_advance  = 1'b0;
        wr_next      = 1'b0;
        wr_addr_next = slot_addr;
        err_set      = 1'b0;
        err_clear    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arm) begin
                    state_next = WAIT_SOF;
                    err_clear  = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            WAIT_SOF: begin
                if (s_valid && s_sof) begin
                    wr_next      = 1'b1;
                    wr_addr_next = '0;
                    cnt_restart  = 1'b1;
                    state_next   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (s_valid) begin
                    if (s_sof && (ch != '0)) begin
                        // early SOF: this sample restarts the block at ch0/idx0
                        err_set      = 1'b1;
                        wr_next      = 1'b1;
                        wr_addr_next = '0;
                        cnt_restart  = 1'b1;
                    end else if (!s_sof && (ch == '0)) begin
                        // missing SOF: drop and resynchronise
                        err_set    = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = WAIT_SOF;
                    end else begin
                        wr_next     = 1'b1;
                        cnt_advance = 1'b1;
                        if (slot_last) state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (done_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // registered RAM write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= wr_next;
            if (wr_next) begin
                wr_addr_reg <= wr_addr_next;
                wr_data_reg <= s_data;
            end
        end
    end

    // sticky framing error, cleared only by an accepted arm
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         sync_err_reg <= 1'b0;
        else if (err_clear) sync_err_reg <= 1'b0;
        else if (err_set)   sync_err_reg <= 1'b1;
    end

`ifdef RAW_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;
    logic        drop;

    assign drop = s_valid && (((state_reg == IDLE) && !arm) ||
                              ((state_reg == WAIT_SOF) && !s_sof) ||
                              (state_reg == DONE));

    // saturating count of samples discarded outside CAPTURE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     drop_cnt_reg <= '0;
        else if (err_clear)                             drop_cnt_reg <= '0;
        else if (drop && (drop_cnt_reg != 16'hFFFF))    drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end

    assign drop_cnt = drop_cnt_reg;
`endif

    assign ram_wr_en    = wr_en_reg;
    assign ram_wr_addr  = wr_addr_reg;
    assign ram_wr_data  = wr_data_reg;
    assign sync_err     = sync_err_reg;
    assign busy         = (state_reg == WAIT_SOF) || (state_reg == CAPTURE);
    assign capture_done = (state_reg == DONE);

endmodule

// File: tb/tb_raw_capture_writer.sv
// Directed bench for raw_capture_writer with a write scoreboard.
module tb_raw_capture_writer;

    logic        clk;
    logic        reset;
    logic        arm;
    logic        s_valid;
    logic        s_sof;
    logic [15:0] s_data;
    logic        ram_wr_en;
    logic [13:0] ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic        busy;
    logic        capture_done;
    logic        sync_err;
    logic        done_ack;
`ifdef RAW_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q[$];

    raw_capture_writer dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .s_valid      (s_valid),
        .s_sof        (s_sof),
        .s_data       (s_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .busy         (busy),
        .capture_done (capture_done),
        .sync_err     (sync_err),
        .done_ack     (done_ack)
`ifdef RAW_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int ch, input int idx);
        logic [15:0] r;
        r = {1'b0, 3'(ch), 12'(idx)};
        return r;
    endfunction

    // drive one cycle; expected write (if any) goes to the scoreboard and is
    // popped when the DUT presents its write strobe
    task automatic step(input logic a, input logic v, input logic sof, input logic ack,
                        input logic [15:0] d, input logic exp_wr, input int exp_addr);
        logic [29:0] e;
        arm = a; s_valid = v; s_sof = sof; done_ack = ack; s_data = d;
        if (exp_wr) exp_q.push_back({14'(exp_addr), d});
        @(posedge clk);
        #1;
        check("wr_en", 32'(ram_wr_en), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (ram_wr_en) begin
                check("wr_addr", 32'(ram_wr_addr), 32'(e[29:16]));
                check("wr_data", 32'(ram_wr_data), 32'(e[15:0]));
            end
        end
        $display("step arm=%0b v=%0b sof=%0b ack=%0b d=%h -> wr=%0b addr=%0d data=%h busy=%0b done=%0b err=%0b",
                 a, v, sof, ack, d, ram_wr_en, ram_wr_addr, ram_wr_data, busy, capture_done, sync_err);
    endtask

    task automatic frame(input int idx);
        for (int c = 0; c < 8; c++)
            step(1'b0, 1'b1, c == 0, 1'b0, mk(c, idx), 1'b1, c * 2048 + idx);
    endtask

    initial begin
        int done_cycles;
        reset = 1'b0; arm = 0; s_valid = 0; s_sof = 0; s_data = '0; done_ack = 0;
        #3;
        check("rst_wr_en", 32'(ram_wr_en), 0);
        check("rst_addr", 32'(ram_wr_addr), 0);
        check("rst_data", 32'(ram_wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(capture_done), 0);
        check("rst_err", 32'(sync_err), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // arm, then early SOF at ch=3
        step(1, 0, 0, 0, 16'h0, 0, 0);
        check("armed_busy", 32'(busy), 1);
        for (int c = 0; c < 3; c++) step(0, 1, c == 0, 0, mk(c, 0), 1, c * 2048);
        step(0, 1, 1, 0, 16'hA5A5, 1, 0);
        check("early_sof_err", 32'(sync_err), 1);
        step(0, 1, 0, 0, mk(1, 0), 1, 2048);

        // arm during CAPTURE is ignored; counters keep going
        step(1, 1, 0, 0, mk(2, 0), 1, 4096);
        check("arm_in_cap_busy", 32'(busy), 1);
        step(1, 0, 0, 0, 16'h0, 0, 0);
        for (int c = 3; c < 8; c++) step(0, 1, 0, 0, mk(c, 0), 1, c * 2048);

        // ch0 without SOF: dropped, back to WAIT_SOF
        step(0, 1, 0, 0, 16'h1234, 0, 0);
        check("missing_sof_err", 32'(sync_err), 1);
        check("missing_sof_busy", 32'(busy), 1);
        step(0, 1, 0, 0, 16'h4321, 0, 0);

        // full block
        for (int i = 0; i < 2047; i++) frame(i);
        for (int c = 0; c < 7; c++) step(0, 1, c == 0, 0, mk(c, 2047), 1, c * 2048 + 2047);
        check("done_before_last", 32'(capture_done), 0);
        step(0, 1, 0, 0, mk(7, 2047), 1, 16383);
        check("done_at_last", 32'(capture_done), 1);
        check("busy_at_last", 32'(busy), 0);
        check("err_sticky", 32'(sync_err), 1);

        // DONE holds with samples streaming in
        done_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 1'($urandom_range(0, 1)), 0, 16'($urandom), 0, 0);
            if (capture_done) done_cycles++;
        end
        check("done_hold_cycles", 32'(done_cycles), 50);
        step(1, 1, 0, 0, 16'h0, 0, 0);
        check("arm_in_done", 32'(capture_done), 1);
        check("arm_in_done_busy", 32'(busy), 0);
        step(1, 0, 0, 1, 16'h0, 0, 0);
        check("ack_done", 32'(capture_done), 0);
        check("ack_arm_busy", 32'(busy), 0);
        step(0, 0, 0, 0, 16'h0, 0, 0);
        check("idle_busy", 32'(busy), 0);
        check("err_before_arm", 32'(sync_err), 1);

        // fresh arm clears the error; leading non-SOF samples are dropped
        step(1, 0, 0, 0, 16'h0, 0, 0);
        check("arm_clears_err", 32'(sync_err), 0);
        check("rearm_busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'(16'hBEE0 + i), 0, 0);
`ifdef RAW_CAPTURE_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 5);
`endif
        frame(0);

        // run to idx=100 then asynchronous reset
        for (int i = 1; i < 100; i++) frame(i);
        for (int c = 0; c < 4; c++) step(0, 1, c == 0, 0, mk(c, 100), 1, c * 2048 + 100);
        arm = 0; s_valid = 0; s_sof = 0; done_ack = 0;
        #2 reset = 1'b0;
        #1;
        check("async_wr_en", 32'(ram_wr_en), 0);
        check("async_addr", 32'(ram_wr_addr), 0);
        check("async_data", 32'(ram_wr_data), 0);
        check("async_busy", 32'(busy), 0);
        check("async_done", 32'(capture_done), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(0, 0, 0, 0, 16'h0, 0, 0);
        check("post_rst_idle", 32'(busy), 0);
        step(1, 0, 0, 0, 16'h0, 0, 0);
        frame(0);
        check("post_rst_busy", 32'(busy), 1);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
